// File: rtl/dac_iq_stream.sv
// I/Q sample FIFO feeding an interleaved DAC bus at 4 clocks per sample.
// Ports: en/dav/ready/i_data/q_data in, dac_d + daciq* controls out, sticky flags, fifo_level.
module dac_iq_stream #(
  parameter int IN_W       = 16,
  parameter int DAC_W      = 14,
  parameter int DEPTH      = 8,
  parameter int OFFSET_BIN = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       dav,
  output logic                       ready,
  input  logic [IN_W-1:0]            i_data,
  input  logic [IN_W-1:0]            q_data,
  input  logic                       calibrate,
  input  logic [IN_W-1:0]            i_dc_cal,
  input  logic [IN_W-1:0]            q_dc_cal,
  input  logic                       clr_status,
  output logic [DAC_W-1:0]           dac_d,
  output logic                       daciqclk,
  output logic                       daciqwrt,
  output logic                       daciqsel,
  output logic                       daciqreset,
  output logic                       underflow,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [IN_W-1:0] mem_i [DEPTH];
  logic [IN_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [LW-1:0]   level;
  logic [1:0]      phase;
  logic [IN_W-1:0] hold_i;
  logic [IN_W-1:0] hold_q;
  logic [IN_W-1:0] nxt_i;
  logic [IN_W-1:0] nxt_q;
  logic            full;
  logic            empty;
  logic            rd_req;
  logic            pop;
  logic            wr;
  logic            clk_r;
  logic            wrt_r;

  function automatic logic [IN_W-1:0] sat_add(
    input logic [IN_W-1:0] a,
    input logic [IN_W-1:0] b
  );
    logic [IN_W:0] s;
    s = {a[IN_W-1], a} + {b[IN_W-1], b};
    if (s[IN_W] != s[IN_W-1])
      sat_add = s[IN_W] ? {1'b1, {(IN_W-1){1'b0}}}
                        : {1'b0, {(IN_W-1){1'b1}}};
    else
      sat_add = s[IN_W-1:0];
  endfunction

  function automatic logic [DAC_W-1:0] to_word(
    input logic [IN_W-1:0] h
  );
    logic [DAC_W-1:0] w;
    w = h[IN_W-1 -: DAC_W];
    if (OFFSET_BIN != 0)
      w[DAC_W-1] = ~w[DAC_W-1];
    to_word = w;
  endfunction

  assign full   = (level == FULL_LVL);
  assign empty  = (level == '0);
  assign ready  = !full;
  assign rd_req = en && (phase == 2'd3);
  assign pop    = rd_req && !empty;
  assign wr     = dav && !full;

  // Storage needs no reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_i[wptr] <= i_data;
      mem_q[wptr] <= q_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      unique case ({wr, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Empty reads and calibrate both fall back to the DC-cal values.
  always_comb begin
    nxt_i = hold_i;
    nxt_q = hold_q;
    unique case (1'b1)
      rd_req && (empty || calibrate): begin
        nxt_i = i_dc_cal;
        nxt_q = q_dc_cal;
      end
      pop && !calibrate: begin
        nxt_i = sat_add(mem_i[rptr], i_dc_cal);
        nxt_q = sat_add(mem_q[rptr], q_dc_cal);
      end
      default: ;
    endcase
  end

  // daciqclk is loaded with the low bit the phase will have after
  // this edge, inverted, so it is high in phases 0 and 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= 2'd0;
      hold_i <= '0;
      hold_q <= '0;
      clk_r  <= 1'b0;
      wrt_r  <= 1'b0;
    end else begin
      if (en) begin
        phase <= phase + 2'd1;
        clk_r <= phase[0];
      end
      hold_i <= nxt_i;
      hold_q <= nxt_q;
      wrt_r  <= clk_r;
    end
  end

  // A set event beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      underflow <= (underflow && !clr_status) || (rd_req && empty);
      overflow  <= (overflow && !clr_status) || (dav && full);
    end
  end

  assign dac_d      = phase[1] ? to_word(hold_i) : to_word(hold_q);
  assign daciqsel   = phase[1];
  assign daciqclk   = clk_r;
  assign daciqwrt   = wrt_r;
  assign daciqreset = 1'b0;
  assign fifo_level = level;

endmodule

// File: tb/tb_dac_iq_stream.sv
// Scoreboard bench for dac_iq_stream: queue-based reference model.
// Directed scenarios followed by randomized traffic.
module tb_dac_iq_stream;

  localparam int IN_W  = 16;
  localparam int DAC_W = 14;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              dav = 1'b0;
  logic              ready;
  logic [IN_W-1:0]   i_data = '0;
  logic [IN_W-1:0]   q_data = '0;
  logic              calibrate = 1'b0;
  logic [IN_W-1:0]   i_dc_cal = '0;
  logic [IN_W-1:0]   q_dc_cal = '0;
  logic              clr_status = 1'b0;
  logic [DAC_W-1:0]  dac_d;
  logic              daciqclk;
  logic              daciqwrt;
  logic              daciqsel;
  logic              daciqreset;
  logic              underflow;
  logic              overflow;
  logic [3:0]        fifo_level;

  dac_iq_stream dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dav(dav), .ready(ready),
    .i_data(i_data), .q_data(q_data), .calibrate(calibrate),
    .i_dc_cal(i_dc_cal), .q_dc_cal(q_dc_cal),
    .clr_status(clr_status), .dac_d(dac_d),
    .daciqclk(daciqclk), .daciqwrt(daciqwrt),
    .daciqsel(daciqsel), .daciqreset(daciqreset),
    .underflow(underflow), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] i; logic [15:0] q; } samp_t;
  typedef struct { logic [13:0] qw; logic [13:0] iw; } exp_t;

  samp_t fifo_m[$];
  exp_t  expq[$];
  int    ph = 0;
  bit    und_m = 0;
  bit    ovf_m = 0;
  bit    ran = 0;
  int    errs = 0;
  int    checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] satm(logic [15:0] a, logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  function automatic logic [13:0] wordm(logic [15:0] h);
    return 14'(h / 4);
  endfunction

  task automatic step();
    bit rd, emp, full, wr;
    samp_t s;
    exp_t e;
    logic [15:0] hi, hq;
    rd   = en && (ph == 3);
    emp  = (fifo_m.size() == 0);
    full = (fifo_m.size() == DEPTH);
    wr   = dav && !full;
    if (clr_status) begin und_m = 0; ovf_m = 0; end
    if (dav && full) ovf_m = 1;
    if (rd) begin
      if (emp) begin
        hi = i_dc_cal; hq = q_dc_cal; und_m = 1;
      end else begin
        s = fifo_m.pop_front();
        hi = calibrate ? i_dc_cal : satm(s.i, i_dc_cal);
        hq = calibrate ? q_dc_cal : satm(s.q, q_dc_cal);
      end
      e.qw = wordm(hq);
      e.iw = wordm(hi);
      expq.push_back(e);
    end
    if (wr) begin
      s.i = i_data; s.q = q_data;
      fifo_m.push_back(s);
    end
    if (en) begin ph = (ph + 1) % 4; ran = 1; end
    @(posedge clk);
    #1;
    chk("level", fifo_level, fifo_m.size());
    chk("ready", ready, fifo_m.size() != DEPTH);
    chk("underflow", underflow, und_m);
    chk("overflow", overflow, ovf_m);
    chk("sel", daciqsel, ph / 2);
    chk("iqreset", daciqreset, 0);
    if (ran) chk("iqclk", daciqclk, (ph % 2) == 0);
  endtask

  task automatic run_to(input int p);
    int g = 0;
    en = 1; dav = 0; clr_status = 0;
    do begin step(); g++; end while (ph != p && g < 8);
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    fifo_m.delete(); expq.delete();
    ph = 0; und_m = 0; ovf_m = 0; ran = 0;
    #1;
    chk("rst_dac", dac_d, 0);
    chk("rst_lvl", fifo_level, 0);
    chk("rst_rdy", ready, 1);
    chk("rst_clk", daciqclk, 0);
    chk("rst_wrt", daciqwrt, 0);
    chk("rst_flags", {underflow, overflow}, 0);
    chk("rst_sel", daciqsel, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  // Monitor: each rising daciqclk is a new DAC presentation.
  initial begin
    logic prev_clk;
    exp_t cur;
    prev_clk = 0;
    cur.qw = 0; cur.iw = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_clk = 0;
        cur.qw = 0; cur.iw = 0;
      end else begin
        chk("wrt", daciqwrt, prev_clk);
        if (daciqclk && !prev_clk) begin
          if (!daciqsel) begin
            if (expq.size() == 0) begin
              checks++; errs++;
              $display("FAIL dac_q: got %0h expected no frame", dac_d);
            end else begin
              cur = expq.pop_front();
              chk("dac_q", dac_d, cur.qw);
            end
          end else begin
            chk("dac_i", dac_d, cur.iw);
          end
        end
        prev_clk = daciqclk;
      end
    end
  end

  function automatic logic [15:0] rnd_data();
    int k = $urandom_range(0, 7);
    if (k == 0) return 16'h7FFF - 16'($urandom_range(0, 15));
    if (k == 1) return 16'h8000 + 16'($urandom_range(0, 15));
    return 16'($urandom);
  endfunction

  function automatic logic [15:0] rnd_cal();
    int k = $urandom_range(0, 3);
    if (k == 0) return 16'($urandom);
    return 16'($signed($urandom_range(0, 1023)) - 512);
  endfunction

  initial begin
    #3;
    chk("init_dac", dac_d, 0);
    chk("init_lvl", fifo_level, 0);
    chk("init_rdy", ready, 1);
    @(posedge clk); #1;
    rst_n = 1;

    en = 1; dav = 1; i_data = 16'h1000; q_data = 16'h2000;
    step();
    run_to(0);
    chk("req37_q", dac_d, 'h0800);
    run_to(2);
    chk("req37_i", dac_d, 'h0400);

    i_dc_cal = 16'h0100; q_dc_cal = 16'h0000;
    en = 1; dav = 1; i_data = 16'h7FF0; q_data = 16'h0000;
    step(); run_to(0); run_to(2);
    chk("sat_hi", dac_d, 'h1FFF);
    i_dc_cal = 16'hFFFF;
    en = 1; dav = 1; i_data = 16'h8000;
    step(); run_to(0); run_to(2);
    chk("sat_lo", dac_d, 'h2000);

    i_dc_cal = 16'h0000; q_dc_cal = 16'h0040;
    run_to(0);
    chk("und_set", underflow, 1);
    chk("und_q", dac_d, 'h0010);
    en = 1; dav = 0; clr_status = 1;
    step();
    clr_status = 0;
    chk("und_clr", underflow, 0);

    en = 0; dav = 1;
    for (int k = 0; k < 9; k++) begin
      i_data = rnd_data(); q_data = rnd_data();
      step();
    end
    chk("ovf_lvl", fifo_level, 8);
    chk("ovf_rdy", ready, 0);
    chk("ovf_set", overflow, 1);
    en = 1; dav = 0;
    for (int k = 0; k < 8; k++) step();
    chk("drain_lvl", fifo_level, 6);

    en = 0; dav = 1;
    while (fifo_m.size() < DEPTH) step();
    calibrate = 1; i_dc_cal = 16'h1234; q_dc_cal = 16'hABCD;
    en = 1; dav = 0;
    for (int k = 0; k < 16; k++) step();
    chk("cal_lvl", fifo_level, 4);
    calibrate = 0; i_dc_cal = 0; q_dc_cal = 0;

    run_to(2);
    en = 0; dav = 1;
    while (fifo_m.size() < 5) step();
    dav = 0;
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      en         = ($urandom_range(0, 9) != 0);
      dav        = $urandom_range(0, 1);
      calibrate  = ($urandom_range(0, 9) == 0);
      clr_status = ($urandom_range(0, 31) == 0);
      i_data     = rnd_data();
      q_data     = rnd_data();
      if ($urandom_range(0, 15) == 0) begin
        i_dc_cal = rnd_cal();
        q_dc_cal = rnd_cal();
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
